// File: rtl/cache_snoop.sv
// Snoop controller for a 4-line direct-mapped cache: looks up bus requests,
// writes back modified lines, then downgrades or invalidates them.
module cache_snoop (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       bus_valid,
    input  logic [1:0] bus_op,
    input  logic [2:0] bus_address,
    output logic       bus_ready,
    input  logic       cpu_we,
    input  logic [2:0] cpu_address,
    input  logic [1:0] cpu_state,
    input  logic [3:0] cpu_data,
    output logic       cpu_stall,
    output logic       wb_valid,
    output logic [2:0] wb_address,
    output logic [3:0] wb_data,
    input  logic       wb_ack,
    output logic       abort,
    output logic       done,
    input  logic [2:0] dbg_address,
    output logic [1:0] dbg_state,
    output logic [3:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, UPDATE} fsm_t;

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_M = 2'b10;

    localparam logic [1:0] OP_RDMISS = 2'b00;
    localparam logic [1:0] OP_INVAL  = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    fsm_t            fsm_q, fsm_d;
    logic [1:0]      op_q;
    logic [2:0]      addr_q;
    logic [3:0]      tag_q;
    logic [3:0][1:0] lst_q;
    logic [3:0][3:0] dat_q;
    logic            done_q;
    logic            first_q;

    logic [1:0]      idx;
    logic [1:0]      cur_st;
    logic            hit;
    logic            cpu_wr;

    // Encoding 11 is stored as written but always read back as Invalid.
    function automatic logic [1:0] norm_state(input logic [1:0] s);
        return (s == 2'b11) ? ST_I : s;
    endfunction

    assign idx    = addr_q[1:0];
    assign cur_st = norm_state(lst_q[idx]);
    assign hit    = (tag_q[idx] == addr_q[2]) && (cur_st != ST_I);

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE:      if (bus_valid) fsm_d = LOOKUP;
            LOOKUP: begin
                if (!hit || op_q == OP_RSVD)
                    fsm_d = IDLE;
                else if (cur_st == ST_M)
                    fsm_d = (op_q == OP_INVAL) ? UPDATE : WRITEBACK;
                else
                    fsm_d = (op_q == OP_RDMISS) ? IDLE : UPDATE;
            end
            WRITEBACK: if (wb_ack) fsm_d = UPDATE;
            UPDATE:    fsm_d = IDLE;
            default:   fsm_d = IDLE;
        endcase
    end

    // Local writes to the index under snoop are dropped so the line stays stable.
    assign cpu_stall = cpu_we && (fsm_q != IDLE) && (cpu_address[1:0] == idx);
    assign cpu_wr    = cpu_we && !cpu_stall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q   <= IDLE;
            op_q    <= 2'b00;
            addr_q  <= 3'b000;
            tag_q   <= 4'b0000;
            lst_q   <= '0;
            dat_q   <= '0;
            done_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            done_q  <= (fsm_q != IDLE) && (fsm_d == IDLE);
            first_q <= (fsm_q != WRITEBACK) && (fsm_d == WRITEBACK);
            if (fsm_q == IDLE && bus_valid) begin
                op_q   <= bus_op;
                addr_q <= bus_address;
            end
            if (cpu_wr) begin
                tag_q[cpu_address[1:0]] <= cpu_address[2];
                lst_q[cpu_address[1:0]] <= cpu_state;
                dat_q[cpu_address[1:0]] <= cpu_data;
            end
            if (fsm_q == UPDATE)
                lst_q[idx] <= (op_q == OP_RDMISS) ? ST_S : ST_I;
        end
    end

    assign bus_ready  = (fsm_q == IDLE);
    assign wb_valid   = (fsm_q == WRITEBACK);
    assign wb_address = wb_valid ? addr_q : 3'b000;
    assign wb_data    = wb_valid ? dat_q[idx] : 4'b0000;
    assign abort      = wb_valid && first_q;
    assign done       = done_q;

    assign dbg_state = (tag_q[dbg_address[1:0]] == dbg_address[2])
                     ? norm_state(lst_q[dbg_address[1:0]]) : ST_I;
    assign dbg_data  = dat_q[dbg_address[1:0]];

endmodule

// File: tb/tb_cache_snoop.sv
// Bench for cache_snoop: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model that queues the expected phases.
module tb_cache_snoop;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       bus_valid;
    logic [1:0] bus_op;
    logic [2:0] bus_address;
    logic       bus_ready;
    logic       cpu_we;
    logic [2:0] cpu_address;
    logic [1:0] cpu_state;
    logic [3:0] cpu_data;
    logic       cpu_stall;
    logic       wb_valid;
    logic [2:0] wb_address;
    logic [3:0] wb_data;
    logic       wb_ack;
    logic       abort;
    logic       done;
    logic [2:0] dbg_address;
    logic [1:0] dbg_state;
    logic [3:0] dbg_data;

    cache_snoop dut (
        .clock(clock), .reset_n(reset_n),
        .bus_valid(bus_valid), .bus_op(bus_op), .bus_address(bus_address),
        .bus_ready(bus_ready),
        .cpu_we(cpu_we), .cpu_address(cpu_address), .cpu_state(cpu_state),
        .cpu_data(cpu_data), .cpu_stall(cpu_stall),
        .wb_valid(wb_valid), .wb_address(wb_address), .wb_data(wb_data),
        .wb_ack(wb_ack), .abort(abort), .done(done),
        .dbg_address(dbg_address), .dbg_state(dbg_state), .dbg_data(dbg_data)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Model: line contents plus a queue of the phases the pending snoop still
    // has to go through (lookup, writeback until acked, update).
    localparam byte PL = 1, PW = 2, PU = 3;
    logic [3:0] mtag;
    logic [1:0] mst [4];
    logic [3:0] mdat [4];
    byte        phq [$];
    logic [1:0] bop;
    logic [2:0] baddr;
    int         wbcnt;
    bit         mdone;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mtag = 4'b0;
        for (int i = 0; i < 4; i++) begin
            mst[i]  = 2'b00;
            mdat[i] = 4'h0;
        end
        phq.delete();
        bop = 2'b00; baddr = 3'b000; wbcnt = 0; mdone = 0;
    endtask

    task automatic model_step();
        bit       busy;
        bit       h;
        int       i;
        busy  = (phq.size() != 0);
        mdone = 0;
        if (busy) begin
            case (phq[0])
                PL: void'(phq.pop_front());
                PW: if (wb_ack) void'(phq.pop_front()); else wbcnt++;
                PU: begin
                    mst[baddr[1:0]] = (bop == 2'b00) ? 2'b01 : 2'b00;
                    void'(phq.pop_front());
                end
                default: ;
            endcase
            if (phq.size() == 0) mdone = 1;
        end
        if (cpu_we && !(busy && cpu_address[1:0] == baddr[1:0])) begin
            i = int'(cpu_address[1:0]);
            mtag[i] = cpu_address[2];
            mst[i]  = (cpu_state == 2'b11) ? 2'b00 : cpu_state;
            mdat[i] = cpu_data;
        end
        if (!busy && bus_valid) begin
            baddr = bus_address;
            bop   = bus_op;
            wbcnt = 0;
            i = int'(baddr[1:0]);
            h = (mtag[i] == baddr[2]) && (mst[i] != 2'b00);
            phq.push_back(PL);
            if (h && bop != 2'b11) begin
                if (mst[i] == 2'b10 && bop != 2'b10) begin
                    phq.push_back(PW); phq.push_back(PU);
                end else if (mst[i] == 2'b10) begin
                    phq.push_back(PU);
                end else if (bop != 2'b00) begin
                    phq.push_back(PU);
                end
            end
        end
    endtask

    task automatic check_all();
        bit         inw;
        logic [1:0] es;
        int         d;
        inw = (phq.size() != 0) && (phq[0] == PW);
        d   = int'(dbg_address[1:0]);
        es  = (mtag[d] == dbg_address[2]) ? mst[d] : 2'b00;
        chk("bus_ready", bus_ready, phq.size() == 0);
        chk("wb_valid", wb_valid, inw);
        chk("wb_address", wb_address, inw ? baddr : 3'b000);
        chk("wb_data", wb_data, inw ? mdat[baddr[1:0]] : 4'h0);
        chk("abort", abort, inw && wbcnt == 0);
        chk("done", done, mdone);
        chk("cpu_stall", cpu_stall,
            cpu_we && phq.size() != 0 && cpu_address[1:0] == baddr[1:0]);
        chk("dbg_state", dbg_state, es);
        chk("dbg_data", dbg_data, mdat[d]);
    endtask

    task automatic cycle();
        #1 check_all();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic idle();
        bus_valid = 0; bus_op = 0; bus_address = 0;
        cpu_we = 0; cpu_address = 0; cpu_state = 0; cpu_data = 0;
        wb_ack = 0;
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [1:0] s, input logic [3:0] dd);
        cpu_we = 1; cpu_address = a; cpu_state = s; cpu_data = dd;
    endtask

    task automatic bus_req(input logic [1:0] op, input logic [2:0] a);
        bus_valid = 1; bus_op = op; bus_address = a;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_wb_valid"}, wb_valid, 0);
        chk({tag, "_bus_ready"}, bus_ready, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_abort"}, abort, 0);
        chk({tag, "_wb_address"}, wb_address, 0);
        chk({tag, "_wb_data"}, wb_data, 0);
        for (int a = 0; a < 8; a++) begin
            dbg_address = 3'(a);
            #1 chk({tag, "_dbg_state"}, dbg_state, 0);
            chk({tag, "_dbg_data"}, dbg_data, 0);
        end
    endtask

    initial begin
        idle();
        dbg_address = 0;
        reset_n = 0;
        model_reset();
        @(negedge clock);
        #1 reset_checks("rst");
        @(negedge clock);
        reset_n = 1;

        // Read miss on an empty cache: lookup only, no abort.
        bus_req(2'b00, 3'd5); cycle(); idle();
        #1 chk("d1_ready_low", bus_ready, 0); chk("d1_no_done", done, 0);
        cycle();
        dbg_address = 5;
        #1 chk("d1_done", done, 1); chk("d1_abort", abort, 0);
        chk("d1_ready", bus_ready, 1); chk("d1_state", dbg_state, 0);
        cycle();
        #1 chk("d1_done_once", done, 0);

        // Write miss hitting S: invalidate without writeback.
        cpu_wr(3'd6, 2'b01, 4'h9); cycle(); idle();
        bus_req(2'b01, 3'd6); cycle(); idle();
        #1 chk("d2_wb_lookup", wb_valid, 0); chk("d2_no_done1", done, 0);
        cycle();
        #1 chk("d2_wb_update", wb_valid, 0); chk("d2_no_done2", done, 0);
        cycle();
        dbg_address = 6;
        #1 chk("d2_done", done, 1); chk("d2_state", dbg_state, 0);
        chk("d2_data", dbg_data, 4'h9);

        // Read miss hitting M with a late ack, plus local writes during writeback.
        cpu_wr(3'd3, 2'b10, 4'hA); cycle(); idle();
        bus_req(2'b00, 3'd3); cycle(); idle();
        cycle();
        #1 chk("d3_abort", abort, 1); chk("d3_wbv1", wb_valid, 1);
        chk("d3_wba", wb_address, 3'd3); chk("d3_wbd", wb_data, 4'hA);
        cpu_wr(3'd7, 2'b01, 4'hF);
        #1 chk("d4_stall", cpu_stall, 1);
        cycle();
        cpu_wr(3'd1, 2'b01, 4'h5);
        #1 chk("d4_nostall", cpu_stall, 0); chk("d3_abort_once", abort, 0);
        chk("d3_wbv2", wb_valid, 1);
        cycle(); idle();
        #1 chk("d3_wbv3", wb_valid, 1);
        cycle();
        wb_ack = 1;
        #1 chk("d3_wbv4", wb_valid, 1); chk("d3_wbd4", wb_data, 4'hA);
        cycle(); idle();
        #1 chk("d3_wb_off", wb_valid, 0); chk("d3_no_done", done, 0);
        cycle();
        dbg_address = 3;
        #1 chk("d3_done", done, 1); chk("d3_state", dbg_state, 2'b01);
        chk("d3_data", dbg_data, 4'hA);
        dbg_address = 7;
        #1 chk("d4_dropped_state", dbg_state, 0); chk("d4_dropped_data", dbg_data, 4'hA);
        dbg_address = 1;
        #1 chk("d4_written_state", dbg_state, 2'b01); chk("d4_written_data", dbg_data, 4'h5);

        // Tag mismatch against a modified line: plain miss.
        cpu_wr(3'd6, 2'b10, 4'hC); cycle(); idle();
        bus_req(2'b00, 3'd2); cycle(); idle();
        #1 chk("d5_wb", wb_valid, 0);
        cycle();
        dbg_address = 6;
        #1 chk("d5_done", done, 1); chk("d5_state", dbg_state, 2'b10);
        chk("d5_data", dbg_data, 4'hC);

        // Reset in the middle of a writeback.
        cpu_wr(3'd0, 2'b10, 4'h7); cycle(); idle();
        bus_req(2'b00, 3'd0); cycle(); idle();
        cycle();
        #1 chk("d6_wb_before", wb_valid, 1);
        reset_n = 0;
        #1 reset_checks("d6");
        model_reset();
        reset_n = 1;

        for (int n = 0; n < 3000; n++) begin
            bus_valid   = ($urandom_range(0, 2) == 0);
            bus_op      = 2'($urandom_range(0, 3));
            bus_address = 3'($urandom_range(0, 7));
            cpu_we      = ($urandom_range(0, 2) == 0);
            cpu_address = 3'($urandom_range(0, 7));
            cpu_state   = 2'($urandom_range(0, 3));
            cpu_data    = 4'($urandom_range(0, 15));
            wb_ack      = ($urandom_range(0, 2) == 0);
            dbg_address = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 399) == 0) begin
                reset_n = 0;
                #1 chk("rnd_rst_wb_valid", wb_valid, 0);
                chk("rnd_rst_ready", bus_ready, 1);
                model_reset();
                reset_n = 1;
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
